// File: rtl/irig_bcd_gen.sv
// IRIG-B (DC level-shift) frame generator.
// Serialises a locally held day/hour/minute/second time into 100-bit, 1 s frames
// (10 ms per bit, high time 2/5/8 ms for 0/1/marker) and advances that time by
// one second at the end of every frame.
//
// Ports:
//   axi_clock  - single clock
//   rst        - synchronous active-high reset
//   en         - run enable (level); a frame in progress always completes
//   load       - 1-cycle strobe loading sec_i/min_i/hr_i/day_i
//   sec_i      - seconds 0..59 (binary)
//   min_i      - minutes 0..59 (binary)
//   hr_i       - hours 0..23 (binary)
//   day_i      - day 0..364 (binary)
//   dout       - IRIG-B level output (registered)
//   pps        - 1-cycle strobe at the rising edge of bit 0 (registered)
//   busy       - a frame is in progress (registered)
//   load_err   - 1-cycle strobe when a load is rejected (registered)
//   time_o     - {day,hr,min,sec} of the current frame, or of the next one when idle
module irig_bcd_gen #(
  parameter int unsigned MS_COUNT = 125000
) (
  input  logic        axi_clock,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [5:0]  sec_i,
  input  logic [5:0]  min_i,
  input  logic [4:0]  hr_i,
  input  logic [8:0]  day_i,
  output logic        dout,
  output logic        pps,
  output logic        busy,
  output logic        load_err,
  output logic [25:0] time_o
);

  localparam int unsigned CNT_W      = (MS_COUNT > 1) ? $clog2(MS_COUNT) : 1;
  localparam int unsigned MIB_W      = 4;
  localparam int unsigned BIT_W      = 7;
  localparam int unsigned FRAME_BITS = 100;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Marker positions: Pr at bit 0, P at every bit ending in 9.
  function automatic logic [FRAME_BITS-1:0] f_markers();
    logic [FRAME_BITS-1:0] m;
    m    = '0;
    m[0] = 1'b1;
    for (int i = 9; i < int'(FRAME_BITS); i += 10) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [FRAME_BITS-1:0] MARKERS = f_markers();

  // Binary-to-BCD of one time value into the data bits of a frame (LSB first).
  function automatic logic [FRAME_BITS-1:0] f_encode(
    input logic [5:0] sec,
    input logic [5:0] mins,
    input logic [4:0] hr,
    input logic [8:0] day
  );
    logic [FRAME_BITS-1:0] v;
    logic [3:0] su, mu, hu, du, dt;
    logic [2:0] st, mt;
    logic [1:0] ht, dh;
    su = 4'(sec % 6'd10);
    st = 3'(sec / 6'd10);
    mu = 4'(mins % 6'd10);
    mt = 3'(mins / 6'd10);
    hu = 4'(hr % 5'd10);
    ht = 2'(hr / 5'd10);
    du = 4'(day % 9'd10);
    dt = 4'((day / 9'd10) % 9'd10);
    dh = 2'(day / 9'd100);
    v        = '0;
    v[4:1]   = su;
    v[8:6]   = st;
    v[13:10] = mu;
    v[17:15] = mt;
    v[23:20] = hu;
    v[26:25] = ht;
    v[33:30] = du;
    v[38:35] = dt;
    v[41:40] = dh;
    return v;
  endfunction

  // State and counters
  logic [0:0]            r_state;
  logic [CNT_W-1:0]      r_ms_cnt;
  logic [MIB_W-1:0]      r_ms_in_bit;
  logic [BIT_W-1:0]      r_bit_idx;
  logic [FRAME_BITS-1:0] r_frame;
  // Time register and pending load
  logic [5:0]            r_sec, r_min;
  logic [4:0]            r_hr;
  logic [8:0]            r_day;
  logic                  r_pend_vld;
  logic [5:0]            r_pend_sec, r_pend_min;
  logic [4:0]            r_pend_hr;
  logic [8:0]            r_pend_day;
  // Registered outputs
  logic                  r_dout, r_pps, r_busy, r_load_err;

  // Next-state values
  logic [0:0]            w_state;
  logic [CNT_W-1:0]      w_ms_cnt;
  logic [MIB_W-1:0]      w_ms_in_bit;
  logic [BIT_W-1:0]      w_bit_idx;
  logic [FRAME_BITS-1:0] w_frame;
  logic [5:0]            w_sec, w_min;
  logic [4:0]            w_hr;
  logic [8:0]            w_day;
  logic                  w_pend_vld;
  logic [5:0]            w_pend_sec, w_pend_min;
  logic [4:0]            w_pend_hr;
  logic [8:0]            w_pend_day;
  logic                  w_dout, w_pps, w_busy, w_load_err;
  logic                  w_load_ok, w_frame_end, w_start;
  logic                  w_c_sec, w_c_min, w_c_hr;
  logic [5:0]            w_inc_sec, w_inc_min;
  logic [4:0]            w_inc_hr;
  logic [8:0]            w_inc_day;
  logic [MIB_W-1:0]      w_high_ms;

  // Next-state, time-keeping and output decode
  always_comb begin
    w_state     = r_state;
    w_ms_cnt    = r_ms_cnt;
    w_ms_in_bit = r_ms_in_bit;
    w_bit_idx   = r_bit_idx;
    w_frame     = r_frame;
    w_sec       = r_sec;
    w_min       = r_min;
    w_hr        = r_hr;
    w_day       = r_day;
    w_pend_vld  = r_pend_vld;
    w_pend_sec  = r_pend_sec;
    w_pend_min  = r_pend_min;
    w_pend_hr   = r_pend_hr;
    w_pend_day  = r_pend_day;
    w_start     = 1'b0;

    w_load_ok   = load && (sec_i < 6'd60) && (min_i < 6'd60) &&
                  (hr_i < 5'd24) && (day_i < 9'd365);
    w_load_err  = load && !w_load_ok;
    w_frame_end = (r_state == S_RUN) && (r_bit_idx == BIT_W'(FRAME_BITS - 1)) &&
                  (r_ms_in_bit == MIB_W'(9)) && (r_ms_cnt == CNT_W'(MS_COUNT - 1));

    // One-second increment with carries sec -> min -> hr -> day (day wraps at 365)
    w_c_sec   = (r_sec == 6'd59);
    w_c_min   = w_c_sec && (r_min == 6'd59);
    w_c_hr    = w_c_min && (r_hr == 5'd23);
    w_inc_sec = w_c_sec ? 6'd0 : r_sec + 6'd1;
    w_inc_min = !w_c_sec ? r_min : (w_c_min ? 6'd0 : r_min + 6'd1);
    w_inc_hr  = !w_c_min ? r_hr  : (w_c_hr  ? 5'd0 : r_hr + 5'd1);
    w_inc_day = !w_c_hr  ? r_day : ((r_day == 9'd364) ? 9'd0 : r_day + 9'd1);

    case (r_state)
      S_IDLE: begin
        if (w_load_ok) begin
          w_sec = sec_i;
          w_min = min_i;
          w_hr  = hr_i;
          w_day = day_i;
        end
        if (en) w_start = 1'b1;
      end
      S_RUN: begin
        if (w_frame_end) begin
          // A load in the boundary cycle takes priority over the pending one.
          if (w_load_ok) begin
            w_sec = sec_i;
            w_min = min_i;
            w_hr  = hr_i;
            w_day = day_i;
          end else if (r_pend_vld) begin
            w_sec = r_pend_sec;
            w_min = r_pend_min;
            w_hr  = r_pend_hr;
            w_day = r_pend_day;
          end else begin
            w_sec = w_inc_sec;
            w_min = w_inc_min;
            w_hr  = w_inc_hr;
            w_day = w_inc_day;
          end
          w_pend_vld = 1'b0;
          if (en) w_start = 1'b1;
          else    w_state = S_IDLE;
        end else begin
          if (r_ms_cnt == CNT_W'(MS_COUNT - 1)) begin
            w_ms_cnt = '0;
            if (r_ms_in_bit == MIB_W'(9)) begin
              w_ms_in_bit = '0;
              w_bit_idx   = r_bit_idx + BIT_W'(1);
            end else begin
              w_ms_in_bit = r_ms_in_bit + MIB_W'(1);
            end
          end else begin
            w_ms_cnt = r_ms_cnt + CNT_W'(1);
          end
          if (w_load_ok) begin
            w_pend_vld = 1'b1;
            w_pend_sec = sec_i;
            w_pend_min = min_i;
            w_pend_hr  = hr_i;
            w_pend_day = day_i;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Frame start: counters restart and the frame content is frozen from the new time.
    if (w_start) begin
      w_state     = S_RUN;
      w_ms_cnt    = '0;
      w_ms_in_bit = '0;
      w_bit_idx   = '0;
      w_frame     = f_encode(w_sec, w_min, w_hr, w_day);
    end

    // Outputs are registered, so they are decoded from the next-cycle position.
    if (MARKERS[w_bit_idx])   w_high_ms = MIB_W'(8);
    else if (w_frame[w_bit_idx]) w_high_ms = MIB_W'(5);
    else                      w_high_ms = MIB_W'(2);
    w_dout = (w_state == S_RUN) && (w_ms_in_bit < w_high_ms);
    w_pps  = w_start;
    w_busy = (w_state == S_RUN);
  end

  // State, counters, time and output registers
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ms_cnt    <= '0;
      r_ms_in_bit <= '0;
      r_bit_idx   <= '0;
      r_frame     <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_hr        <= '0;
      r_day       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_sec  <= '0;
      r_pend_min  <= '0;
      r_pend_hr   <= '0;
      r_pend_day  <= '0;
      r_dout      <= 1'b0;
      r_pps       <= 1'b0;
      r_busy      <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_ms_cnt    <= w_ms_cnt;
      r_ms_in_bit <= w_ms_in_bit;
      r_bit_idx   <= w_bit_idx;
      r_frame     <= w_frame;
      r_sec       <= w_sec;
      r_min       <= w_min;
      r_hr        <= w_hr;
      r_day       <= w_day;
      r_pend_vld  <= w_pend_vld;
      r_pend_sec  <= w_pend_sec;
      r_pend_min  <= w_pend_min;
      r_pend_hr   <= w_pend_hr;
      r_pend_day  <= w_pend_day;
      r_dout      <= w_dout;
      r_pps       <= w_pps;
      r_busy      <= w_busy;
      r_load_err  <= w_load_err;
    end
  end

  assign dout     = r_dout;
  assign pps      = r_pps;
  assign busy     = r_busy;
  assign load_err = r_load_err;
  assign time_o   = {r_day, r_hr, r_min, r_sec};

endmodule

// File: tb/tb_irig_bcd_gen.sv
// Bench for irig_bcd_gen: reset behaviour, idle load validation (table and random),
// frame encoding decoded from dout pulse widths, running/pending loads, rollover,
// disable mid-frame and reset mid-bit.
module tb_irig_bcd_gen;

  localparam int MS    = 10;
  localparam int FRAME = 1000 * MS;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [5:0]  sec_i, min_i;
  logic [4:0]  hr_i;
  logic [8:0]  day_i;
  logic        dout, pps, busy, load_err;
  logic [25:0] time_o;

  always #5 clk = ~clk;

  irig_bcd_gen #(.MS_COUNT(MS)) dut (
    .axi_clock(clk), .rst(rst), .en(en), .load(load),
    .sec_i(sec_i), .min_i(min_i), .hr_i(hr_i), .day_i(day_i),
    .dout(dout), .pps(pps), .busy(busy), .load_err(load_err), .time_o(time_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] mk(input int dy, input int hr, input int mn, input int sc);
    return {9'(dy), 5'(hr), 6'(mn), 6'(sc)};
  endfunction

  // Reference: time as seconds-of-year, +1, modulo one 365-day year.
  function automatic logic [25:0] model_inc(input logic [25:0] t);
    int total;
    total = ((int'(t[25:17]) * 24 + int'(t[16:12])) * 60 + int'(t[11:6])) * 60 + int'(t[5:0]);
    total = (total + 1) % (365 * 86400);
    return mk(total / 86400, (total / 3600) % 24, (total / 60) % 60, total % 60);
  endfunction

  // Reference symbol for bit i of a frame carrying time t: 0, 1 or 2 (= marker).
  function automatic int model_sym(input logic [25:0] t, input int i);
    int sc, mn, hr, dy;
    int gs[9];
    int gl[9];
    int gv[9];
    if (i == 0 || i % 10 == 9) return 2;
    sc = int'(t[5:0]); mn = int'(t[11:6]); hr = int'(t[16:12]); dy = int'(t[25:17]);
    gs = '{1, 6, 10, 15, 20, 25, 30, 35, 40};
    gl = '{4, 3, 4, 3, 4, 2, 4, 4, 2};
    gv = '{sc % 10, sc / 10, mn % 10, mn / 10, hr % 10, hr / 10, dy % 10, (dy / 10) % 10, dy / 100};
    for (int g = 0; g < 9; g++)
      if (i >= gs[g] && i < gs[g] + gl[g]) return (gv[g] >> (i - gs[g])) & 1;
    return 0;
  endfunction

  // Monitor: classify each high pulse of dout into a symbol, per frame (pps-delimited).
  int  dec[4][100];
  int  nbits[4];
  int  pps_cyc[8];
  int  n_pps  = 0;
  int  cyc    = 0;
  bit  mon_en = 1'b0;

  initial begin
    int   hi;
    int   cur;
    int   bp;
    logic prev_dout;
    hi = 0; cur = -1; bp = 0; prev_dout = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (pps) begin
          if (n_pps < 8) pps_cyc[n_pps] = cyc;
          n_pps++;
          cur = n_pps - 1;
          bp  = 0;
        end
        if (dout) hi++;
        else if (prev_dout) begin
          if (cur >= 0 && cur < 4 && bp < 100) begin
            dec[cur][bp] = (hi == 2 * MS) ? 0 : (hi == 5 * MS) ? 1 : (hi == 8 * MS) ? 2 : 3;
            nbits[cur]   = bp + 1;
          end
          bp++;
          hi = 0;
        end
        prev_dout = dout;
      end
    end
  end

  // Independent BCD decoder of a captured frame.
  function automatic int digit(input int f, input int start, input int len);
    int v;
    v = 0;
    for (int k = 0; k < len; k++) if (dec[f][start + k] == 1) v += (1 << k);
    return v;
  endfunction

  function automatic logic [25:0] decode_frame(input int f);
    return mk(digit(f, 30, 4) + 10 * digit(f, 35, 4) + 100 * digit(f, 40, 2),
              digit(f, 20, 4) + 10 * digit(f, 25, 2),
              digit(f, 10, 4) + 10 * digit(f, 15, 3),
              digit(f, 1, 4) + 10 * digit(f, 6, 3));
  endfunction

  // Called at a negedge: drive a 1-cycle load; returns at the next negedge.
  task automatic do_load(input int dy, input int hr, input int mn, input int sc);
    day_i = 9'(dy); hr_i = 5'(hr); min_i = 6'(mn); sec_i = 6'(sc);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_pps(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (pps) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  typedef struct {
    int          sc;
    int          mn;
    int          hr;
    int          dy;
    bit          exp_err;
    logic [25:0] exp_time;
  } vec_t;

  vec_t        vecs[7];
  logic [25:0] exp_t[4];

  initial begin
    logic [25:0] mt;
    int          stray;
    int          mism;
    int          aidx[19];
    int          aval[19];

    rst = 1'b1; en = 1'b1; load = 1'b0;
    sec_i = '0; min_i = '0; hr_i = '0; day_i = '0;

    vecs[0] = '{59, 59, 23, 364, 1'b0, mk(364, 23, 59, 59)};
    vecs[1] = '{60,  0,  0,   0, 1'b1, mk(364, 23, 59, 59)};
    vecs[2] = '{ 0, 60,  0,   0, 1'b1, mk(364, 23, 59, 59)};
    vecs[3] = '{ 0,  0, 24,   0, 1'b1, mk(364, 23, 59, 59)};
    vecs[4] = '{ 0,  0,  0, 365, 1'b1, mk(364, 23, 59, 59)};
    vecs[5] = '{ 0,  0,  0,   0, 1'b0, mk(0, 0, 0, 0)};
    vecs[6] = '{56, 34, 12, 123, 1'b0, mk(123, 12, 34, 56)};

    // Reset held with en=1: every output stays 0.
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_outputs", 64'({dout, pps, busy, load_err, time_o}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("start_pps", 64'(pps), 64'd1);
    chk("start_dout", 64'(dout), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("pps_one_cycle", 64'(pps), 64'd0);
    chk("dout_mid_bit0", 64'(dout), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_bit_dout", 64'(dout), 64'd0);
    chk("rst_mid_bit_busy", 64'(busy), 64'd0);
    en  = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Random idle loads against the range rules.
    mt = '0;
    for (int i = 0; i < 40; i++) begin
      int sc, mn, hr, dy;
      bit valid;
      sc = int'($urandom_range(0, 63));
      mn = int'($urandom_range(0, 63));
      hr = int'($urandom_range(0, 31));
      dy = int'($urandom_range(0, 511));
      if (i % 3 == 0) begin
        sc = sc % 60; mn = mn % 60; hr = hr % 24; dy = dy % 365;
      end
      do_load(dy, hr, mn, sc);
      valid = (sc < 60) && (mn < 60) && (hr < 24) && (dy < 365);
      if (valid) mt = mk(dy, hr, mn, sc);
      chk("rand_load_err", 64'(load_err), 64'(!valid));
      chk("rand_load_time", 64'(time_o), 64'(mt));
      @(negedge clk);
      chk("rand_load_err_pulse", 64'(load_err), 64'd0);
    end

    // Table-driven idle loads, including field boundaries.
    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].dy, vecs[i].hr, vecs[i].mn, vecs[i].sc);
      chk("tbl_load_err", 64'(load_err), 64'(vecs[i].exp_err));
      chk("tbl_load_time", 64'(time_o), 64'(vecs[i].exp_time));
      @(negedge clk);
      chk("tbl_load_err_pulse", 64'(load_err), 64'd0);
    end

    // Frame A: 123 d 12:34:56; two loads while running, the second wins.
    exp_t[0] = vecs[6].exp_time;
    mon_en   = 1'b1;
    en       = 1'b1;
    wait_pps("pps_frame_a");
    chk("time_frame_a", 64'(time_o), 64'(exp_t[0]));
    repeat (4000) @(negedge clk);
    do_load(1, 1, 1, 1);
    chk("run_load_no_err", 64'(load_err), 64'd0);
    chk("run_load_time_hold", 64'(time_o), 64'(exp_t[0]));
    repeat (999) @(negedge clk);
    do_load(364, 23, 59, 59);
    exp_t[1] = mk(364, 23, 59, 59);

    // Frame B from the pending load, then C rolls over to zero.
    wait_pps("pps_frame_b");
    chk("time_frame_b", 64'(time_o), 64'(exp_t[1]));
    exp_t[2] = model_inc(exp_t[1]);
    wait_pps("pps_frame_c");
    chk("time_frame_c", 64'(time_o), 64'(exp_t[2]));
    chk("rollover_time_zero", 64'(time_o), 64'd0);
    repeat (5000) @(negedge clk);
    do_load(0, 0, 0, 10);
    exp_t[3] = mk(0, 0, 0, 10);
    chk("run_load_time_hold_c", 64'(time_o), 64'(exp_t[2]));
    repeat (999) @(negedge clk);
    do_load(int'($urandom_range(0, 364)), 0, 0, int'($urandom_range(60, 63)));
    chk("reject_load_err", 64'(load_err), 64'd1);
    chk("reject_load_time", 64'(time_o), 64'(exp_t[2]));
    @(negedge clk);
    chk("reject_load_err_pulse", 64'(load_err), 64'd0);

    // Frame D carries sec 10; disable at bit 30, frame still completes.
    wait_pps("pps_frame_d");
    chk("time_frame_d", 64'(time_o), 64'(exp_t[3]));
    repeat (3000) @(negedge clk);
    en = 1'b0;
    repeat (6999) @(negedge clk);
    chk("disable_last_cycle_busy", 64'(busy), 64'd1);
    chk("disable_last_cycle_dout", 64'(dout), 64'd0);
    @(negedge clk);
    chk("disable_idle_busy", 64'(busy), 64'd0);
    chk("disable_idle_time", 64'(time_o), 64'(model_inc(exp_t[3])));
    stray = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pps || dout || busy) stray++;
    end
    chk("disable_idle_quiet", 64'(stray), 64'd0);

    // Decoded frames against the reference model.
    chk("pps_count", 64'(n_pps), 64'd4);
    for (int f = 1; f < 4; f++) chk("pps_period", 64'(pps_cyc[f] - pps_cyc[f - 1]), 64'(FRAME));
    for (int f = 0; f < 4; f++) begin
      chk("frame_nbits", 64'(nbits[f]), 64'd100);
      mism = 0;
      for (int i = 0; i < 100; i++) if (dec[f][i] != model_sym(exp_t[f], i)) mism++;
      chk($sformatf("frame%0d_symbols", f), 64'(mism), 64'd0);
      chk($sformatf("frame%0d_loopback_time", f), 64'(decode_frame(f)), 64'(exp_t[f]));
    end
    aidx = '{0, 9, 1, 2, 3, 4, 6, 7, 8, 30, 31, 32, 33, 35, 36, 37, 38, 40, 41};
    aval = '{2, 2, 0, 1, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0};
    for (int k = 0; k < 19; k++)
      chk($sformatf("frame_a_bit%0d", aidx[k]), 64'(dec[0][aidx[k]]), 64'(aval[k]));
    chk("frame_d_bit99_marker", 64'(dec[3][99]), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
